// File: rtl/slc3_core_hs.sv
// SLC-3 subset datapath with an integrated multicycle sequencer and a req/ack memory port.
// Optional LDI/STI support is compiled in when SLC3_INDIRECT_EN is defined.
module slc3_core_hs #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_i,
  input  logic              continue_i,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [11:0]       led_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [15:0]       ir_o,
  output logic              halted_o,
  output logic              paused_o
);

  if (DATA_W < 16 || ADDR_W > DATA_W) begin : g_bad_params
    $error("slc3_core_hs: need DATA_W >= 16 and ADDR_W <= DATA_W");
  end

  localparam logic [3:0] S_HALTED  = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXEC    = 4'd3;
  localparam logic [3:0] S_ADDR    = 4'd4;
  localparam logic [3:0] S_MEM_RD  = 4'd5;
  localparam logic [3:0] S_WB      = 4'd6;
  localparam logic [3:0] S_MEM_WR  = 4'd7;
  localparam logic [3:0] S_PAUSED  = 4'd8;
`ifdef SLC3_INDIRECT_EN
  localparam logic [3:0] S_IND_RD  = 4'd9;
  localparam logic [3:0] S_IND_PTR = 4'd10;
`endif

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [15:0]       ir_q, ir_d;
  logic [2:0]        cc_q, cc_d;
  logic [11:0]       led_q, led_d;
  logic [DATA_W-1:0] rf_q [8];

  logic              rfWe;
  logic [2:0]        rfWaddr;
  logic [DATA_W-1:0] rfWdata;

  logic [3:0]        opcode;
  logic [DATA_W-1:0] srcA, srcB, srcDr, aluResult;
  logic [DATA_W-1:0] imm5X, off6X;
  logic [ADDR_W-1:0] off9A, off11A;

  function automatic logic [2:0] ccOf(input logic [DATA_W-1:0] r);
    if (r[DATA_W-1]) return 3'b100;
    else if (r == '0) return 3'b010;
    else return 3'b001;
  endfunction

  assign opcode = ir_q[15:12];
  assign imm5X  = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
  assign off6X  = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
  assign off9A  = ADDR_W'({{(DATA_W-9){ir_q[8]}}, ir_q[8:0]});
  assign off11A = ADDR_W'({{(DATA_W-11){ir_q[10]}}, ir_q[10:0]});
  assign srcA   = rf_q[ir_q[8:6]];
  assign srcB   = ir_q[5] ? imm5X : rf_q[ir_q[2:0]];
  assign srcDr  = rf_q[ir_q[11:9]];

  always_comb begin
    unique case (opcode)
      4'b0001: aluResult = srcA + srcB;
      4'b0101: aluResult = srcA & srcB;
      default: aluResult = ~srcA;
    endcase
  end

  // Request outputs decode from the state register alone, so an async reset drops mem_req at once.
  always_comb begin
    mem_req = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
`ifdef SLC3_INDIRECT_EN
    if (state_q == S_IND_RD) mem_req = 1'b1;
`endif
  end

  assign mem_we    = (state_q == S_MEM_WR);
  assign mem_addr  = (state_q == S_FETCH) ? pc_q : mar_q;
  assign mem_wdata = mdr_q;
  assign led_o     = led_q;
  assign pc_o      = pc_q;
  assign ir_o      = ir_q;
  assign halted_o  = (state_q == S_HALTED);
  assign paused_o  = (state_q == S_PAUSED);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cc_d    = cc_q;
    led_d   = led_q;
    rfWe    = 1'b0;
    rfWaddr = ir_q[11:9];
    rfWdata = aluResult;
    case (state_q)
      S_HALTED: if (run_i) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata[15:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          4'b0110, 4'b0111: state_d = S_ADDR;
`ifdef SLC3_INDIRECT_EN
          4'b1010, 4'b1011: state_d = S_ADDR;
`endif
          default:          state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          4'b0001, 4'b0101, 4'b1001: begin
            rfWe = 1'b1;
            cc_d = ccOf(aluResult);
          end
          4'b0000: if ((ir_q[11:9] & cc_q) != 3'b000) pc_d = pc_q + off9A;
          4'b1100: pc_d = ADDR_W'(srcA);
          // R7 is read combinationally, so JSRR R7 still sees the old link value.
          4'b0100: begin
            rfWe    = 1'b1;
            rfWaddr = 3'd7;
            rfWdata = DATA_W'(pc_q);
            pc_d    = ir_q[11] ? (pc_q + off11A) : ADDR_W'(srcA);
          end
          4'b1101: begin
            led_d   = ir_q[11:0];
            state_d = S_PAUSED;
          end
          default: ;
        endcase
      end
      S_ADDR: begin
`ifdef SLC3_INDIRECT_EN
        if (opcode[3]) begin
          mar_d   = pc_q + off9A;
          state_d = S_IND_RD;
        end else begin
`endif
          mar_d = ADDR_W'(srcA + off6X);
          if (opcode == 4'b0111) begin
            mdr_d   = srcDr;
            state_d = S_MEM_WR;
          end else begin
            state_d = S_MEM_RD;
          end
`ifdef SLC3_INDIRECT_EN
        end
`endif
      end
      S_MEM_RD: begin
        if (mem_ack) begin
          mdr_d   = mem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        rfWe    = 1'b1;
        rfWdata = mdr_q;
        cc_d    = ccOf(mdr_q);
        state_d = S_FETCH;
      end
      S_MEM_WR: if (mem_ack) state_d = S_FETCH;
      S_PAUSED: if (continue_i) state_d = S_FETCH;
`ifdef SLC3_INDIRECT_EN
      S_IND_RD: begin
        if (mem_ack) begin
          mdr_d   = mem_rdata;
          state_d = S_IND_PTR;
        end
      end
      S_IND_PTR: begin
        mar_d = mdr_q[ADDR_W-1:0];
        if (opcode[0]) begin
          mdr_d   = srcDr;
          state_d = S_MEM_WR;
        end else begin
          state_d = S_MEM_RD;
        end
      end
`endif
      default: state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_HALTED;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      cc_q    <= 3'b010;
      led_q   <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cc_q    <= cc_d;
      led_q   <= led_d;
      if (rfWe) rf_q[rfWaddr] <= rfWdata;
    end
  end

endmodule
